// File: rtl/seg_display_sequencer_if.sv
// Bundle between the datapath, the display sequencer and the seven-segment driver.
// The master drives the sources and controls. The slave is the sequencer.
interface seg_display_sequencer_if;
   logic [127:0] src_data;
   logic [3:0]   src_valid;
   logic         btn_next;
   logic         auto_en;
   logic         freeze;
   logic [31:0]  displayed_number;
   logic         p;
   logic [1:0]   cur_src;
   logic         active;

   modport master (
      output src_data, src_valid, btn_next, auto_en, freeze,
      input  displayed_number, p, cur_src, active
   );

   modport slave (
      input  src_data, src_valid, btn_next, auto_en, freeze,
      output displayed_number, p, cur_src, active
   );
endinterface

// File: rtl/seg_display_sequencer.sv
// Shares the 4-digit seven-segment display between up to four 32-bit sources.
// Each source is shown as a high page and then a low page.
// A page advances on a dwell timer or on a debounced button press.
// The word is snapshotted on reload so that both halves come from the same value.
module seg_display_sequencer #(
   parameter int unsigned DWELL_CYCLES    = 200_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input logic                    clock_100Mhz,
   input logic                    reset,
   seg_display_sequencer_if.slave bus
);

   localparam int unsigned DwellW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
   localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   typedef enum logic [1:0] {StIdle, StShowHi, StShowLo} state_e;

   state_e              state_q, state_d;
   logic [31:0]         disp_q, disp_d;
   logic [1:0]          cur_src_q, cur_src_d;
   logic                p_q, active_q;
   logic                btn_meta_q, btn_sync_q;
   logic                btn_deb_q, btn_deb_d, btn_deb_prev_q;
   logic [DebW-1:0]     deb_cnt_q, deb_cnt_d;
   logic                adv_btn_q;
   logic [DwellW-1:0]   dwell_cnt_q, dwell_cnt_d;
   logic                adv_tmr, adv, page_change;
   logic [1:0]          first_src, next_src;
   logic [31:0]         src_word [4];

   // Synchronizer, debounced level and rising-edge pulse of the button.
   // An edge seen while frozen is dropped rather than held back.
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         btn_meta_q     <= 1'b0;
         btn_sync_q     <= 1'b0;
         btn_deb_q      <= 1'b0;
         btn_deb_prev_q <= 1'b0;
         deb_cnt_q      <= '0;
         adv_btn_q      <= 1'b0;
      end else begin
         btn_meta_q     <= bus.btn_next;
         btn_sync_q     <= btn_meta_q;
         btn_deb_q      <= btn_deb_d;
         btn_deb_prev_q <= btn_deb_q;
         deb_cnt_q      <= deb_cnt_d;
         adv_btn_q      <= btn_deb_q & ~btn_deb_prev_q & ~bus.freeze;
      end
   end

   // Accept the synchronized level once it has differed for DEBOUNCE_CYCLES cycles in a row.
   always_comb begin
      deb_cnt_d = deb_cnt_q;
      btn_deb_d = btn_deb_q;
      if (btn_sync_q == btn_deb_q) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == DebW'(DEBOUNCE_CYCLES - 1)) begin
         btn_deb_d = btn_sync_q;
         deb_cnt_d = '0;
      end else begin
         deb_cnt_d = deb_cnt_q + DebW'(1);
      end
   end

   // Advance requests. A simultaneous button pulse and timer pulse give a single advance.
   always_comb begin
      adv_tmr = bus.auto_en & ~bus.freeze & (state_q != StIdle) &
                (dwell_cnt_q == DwellW'(DWELL_CYCLES - 1));
      adv     = (adv_btn_q | adv_tmr) & ~bus.freeze;
   end

   // Source selection: the lowest valid index for an IDLE exit.
   // For a page advance, the next valid index after cur_src, wrapping back to cur_src itself.
   always_comb begin
      logic [1:0] idx;
      logic       found;
      for (int k = 0; k < 4; k++) begin
         src_word[k] = bus.src_data[32*k +: 32];
      end
      first_src = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (bus.src_valid[k]) first_src = 2'(k);
      end
      next_src = cur_src_q;
      found    = 1'b0;
      idx      = cur_src_q;
      for (int k = 1; k <= 4; k++) begin
         idx = cur_src_q + 2'(k);
         if (!found && bus.src_valid[idx]) begin
            next_src = idx;
            found    = 1'b1;
         end
      end
   end

   // Page FSM next-state logic. Losing the shown source forces an advance even while frozen.
   always_comb begin
      state_d     = state_q;
      disp_d      = disp_q;
      cur_src_d   = cur_src_q;
      page_change = 1'b0;
      case (state_q)
         StIdle: begin
            if (|bus.src_valid) begin
               disp_d      = src_word[first_src];
               cur_src_d   = first_src;
               state_d     = StShowHi;
               page_change = 1'b1;
            end
         end
         StShowHi, StShowLo: begin
            if (!bus.src_valid[cur_src_q]) begin
               page_change = 1'b1;
               if (|bus.src_valid) begin
                  disp_d    = src_word[next_src];
                  cur_src_d = next_src;
                  state_d   = StShowHi;
               end else begin
                  state_d   = StIdle;
               end
            end else if (adv) begin
               page_change = 1'b1;
               if (state_q == StShowHi) begin
                  state_d = StShowLo;
               end else begin
                  disp_d    = src_word[next_src];
                  cur_src_d = next_src;
                  state_d   = StShowHi;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Dwell count: cleared on any page change, while idle and while auto mode is off; held while frozen.
   always_comb begin
      dwell_cnt_d = dwell_cnt_q;
      if (!bus.auto_en || page_change || state_q == StIdle) begin
         dwell_cnt_d = '0;
      end else if (!bus.freeze) begin
         dwell_cnt_d = dwell_cnt_q + DwellW'(1);
      end
   end

   // State, snapshot and registered outputs.
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         disp_q      <= '0;
         cur_src_q   <= 2'd0;
         p_q         <= 1'b0;
         active_q    <= 1'b0;
         dwell_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         disp_q      <= disp_d;
         cur_src_q   <= cur_src_d;
         p_q         <= (state_d == StShowHi);
         active_q    <= (state_d != StIdle);
         dwell_cnt_q <= dwell_cnt_d;
      end
   end

   assign bus.displayed_number = disp_q;
   assign bus.p                = p_q;
   assign bus.cur_src          = cur_src_q;
   assign bus.active           = active_q;

endmodule
